// File: rtl/instruction_store.sv
// instruction_store: instruction buffer with a registered memory read and a prefetch output
// stage. REPLAY=0 behaves as a consuming FIFO; REPLAY=1 retains a sealed program that can be rewound.
module instruction_store #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter int REPLAY     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_last,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  input  logic                    rewind,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C      = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] ZERO_C     = {(ADDR_WIDTH+1){1'b0}};

  logic [DATA_WIDTH:0]   mem_r [DEPTH];
  logic [DATA_WIDTH:0]   mem_word_r;
  // Pointers carry one extra bit so "all fetched" and "buffer full" stay distinguishable.
  logic [ADDR_WIDTH:0]   wr_ptr_r;
  logic [ADDR_WIDTH:0]   rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  sealed_r;
  logic                  overflow_r;
  logic                  wr_ready_r;
  logic                  mem_valid_r;
  logic                  rd_valid_r;
  logic                  rd_last_r;
  logic [DATA_WIDTH-1:0] rd_data_r;

  logic                  wr_xfer_s;
  logic                  rd_xfer_s;
  logic                  rewind_s;
  logic                  avail_s;
  logic                  advance_s;
  logic                  fetch_s;
  logic [ADDR_WIDTH:0]   count_next_s;
  logic                  sealed_next_s;
  logic                  wr_ready_next_s;

  // Handshake decode, prefetch pipeline control and next occupancy.
  always_comb begin
    wr_xfer_s = wr_valid & wr_ready_r;
    rd_xfer_s = rd_valid_r & rd_ready;
    rewind_s  = (REPLAY != 0) ? rewind : 1'b0;
    avail_s   = (rd_ptr_r != wr_ptr_r);
    advance_s = mem_valid_r & (~rd_valid_r | rd_xfer_s);
    fetch_s   = avail_s & (~mem_valid_r | advance_s) & ~rewind_s;
    if (REPLAY != 0) begin
      count_next_s    = wr_xfer_s ? (count_r + ONE_C) : count_r;
      sealed_next_s   = sealed_r | (wr_xfer_s & wr_last);
      wr_ready_next_s = ~sealed_next_s & (count_next_s < FULL_COUNT);
    end else begin
      case ({wr_xfer_s, rd_xfer_s})
        2'b10:   count_next_s = count_r + ONE_C;
        2'b01:   count_next_s = count_r - ONE_C;
        default: count_next_s = count_r;
      endcase
      sealed_next_s   = 1'b0;
      wr_ready_next_s = (count_next_s < FULL_COUNT);
    end
  end

  // Control state, pointers and the presented-entry output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r    <= ZERO_C;
      rd_ptr_r    <= ZERO_C;
      count_r     <= ZERO_C;
      sealed_r    <= 1'b0;
      overflow_r  <= 1'b0;
      wr_ready_r  <= 1'b0;
      mem_valid_r <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd_last_r   <= 1'b0;
      rd_data_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      count_r    <= count_next_s;
      sealed_r   <= sealed_next_s;
      wr_ready_r <= wr_ready_next_s;
      overflow_r <= overflow_r | (wr_valid & ~wr_ready_r);
      if (wr_xfer_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_C;
      end
      // Rewind discards both prefetched words; a coincident read transfer has already completed.
      if (rewind_s) begin
        rd_ptr_r    <= ZERO_C;
        mem_valid_r <= 1'b0;
        rd_valid_r  <= 1'b0;
      end else begin
        if (fetch_s) begin
          rd_ptr_r    <= rd_ptr_r + ONE_C;
          mem_valid_r <= 1'b1;
        end else if (advance_s) begin
          mem_valid_r <= 1'b0;
        end
        if (advance_s) begin
          rd_valid_r <= 1'b1;
          rd_data_r  <= mem_word_r[DATA_WIDTH-1:0];
          rd_last_r  <= mem_word_r[DATA_WIDTH];
        end else if (rd_xfer_s) begin
          rd_valid_r <= 1'b0;
        end
      end
    end
  end

  // Storage array: synchronous write and registered read, never reset.
  always_ff @(posedge clk) begin
    if (wr_xfer_s) begin
      mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= {wr_last, wr_data};
    end
    if (fetch_s) begin
      mem_word_r <= mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
    end
  end

  assign wr_ready = wr_ready_r;
  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_data_r;
  assign rd_last  = rd_last_r;
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_instruction_store.sv
// Self-checking bench: directed FIFO and replay scenarios plus a randomized FIFO run
// scored against a queue model.
module tb_instruction_store;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_tests  = 0;
  int n_failed = 0;

  // Instance A: FIFO, DEPTH=4
  logic       a_wr_valid, a_wr_ready, a_wr_last, a_rd_valid, a_rd_ready, a_rd_last, a_rewind, a_overflow;
  logic [7:0] a_wr_data, a_rd_data;
  logic [2:0] a_count;
  // Instance B: FIFO, DEPTH=8, randomized
  logic        b_wr_valid, b_wr_ready, b_wr_last, b_rd_valid, b_rd_ready, b_rd_last, b_rewind, b_overflow;
  logic [15:0] b_wr_data, b_rd_data;
  logic [3:0]  b_count;
  // Instance C: replay, DEPTH=8
  logic       c_wr_valid, c_wr_ready, c_wr_last, c_rd_valid, c_rd_ready, c_rd_last, c_rewind, c_overflow;
  logic [7:0] c_wr_data, c_rd_data;
  logic [3:0] c_count;

  instruction_store #(.DATA_WIDTH(8), .DEPTH(4), .REPLAY(0)) u_a (
    .clk(clk), .reset(reset), .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_data(a_wr_data),
    .wr_last(a_wr_last), .rd_valid(a_rd_valid), .rd_ready(a_rd_ready), .rd_data(a_rd_data),
    .rd_last(a_rd_last), .rewind(a_rewind), .count(a_count), .overflow(a_overflow));

  instruction_store #(.DATA_WIDTH(16), .DEPTH(8), .REPLAY(0)) u_b (
    .clk(clk), .reset(reset), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data),
    .wr_last(b_wr_last), .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_data(b_rd_data),
    .rd_last(b_rd_last), .rewind(b_rewind), .count(b_count), .overflow(b_overflow));

  instruction_store #(.DATA_WIDTH(8), .DEPTH(8), .REPLAY(1)) u_c (
    .clk(clk), .reset(reset), .wr_valid(c_wr_valid), .wr_ready(c_wr_ready), .wr_data(c_wr_data),
    .wr_last(c_wr_last), .rd_valid(c_rd_valid), .rd_ready(c_rd_ready), .rd_data(c_rd_data),
    .rd_last(c_rd_last), .rewind(c_rewind), .count(c_count), .overflow(c_overflow));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Replay model: the retained program and the index of the next entry to read out.
  logic [8:0] c_prog[$];
  int         c_idx    = 0;
  bit         c_sealed = 1'b0;
  int         c_xfers  = 0;

  task automatic c_write(input logic [7:0] data, input logic last);
    logic exp_ready;
    exp_ready  = !c_sealed && (c_prog.size() < 8);
    c_wr_valid = 1'b1;
    c_wr_data  = data;
    c_wr_last  = last;
    check("c_wr_ready", c_wr_ready, exp_ready);
    if (exp_ready) begin
      c_prog.push_back({last, data});
      if (last) c_sealed = 1'b1;
    end
    tick();
    c_wr_valid = 1'b0;
  endtask

  task automatic c_cycle(input logic rdy, input logic rw);
    logic [8:0] exp_word;
    c_rd_ready = rdy;
    c_rewind   = rw;
    if (c_rd_valid && rdy) begin
      c_xfers++;
      if (c_idx < c_prog.size()) begin
        exp_word = c_prog[c_idx];
        check("c_rd_data", {23'd0, c_rd_last, c_rd_data}, {23'd0, exp_word});
      end else begin
        check("c_rd_valid_past_end", c_rd_valid, 1'b0);
      end
      c_idx++;
    end
    if (rw) c_idx = 0;
    tick();
    c_rd_ready = 1'b0;
    c_rewind   = 1'b0;
  endtask

  logic [7:0]  got[$];
  logic [16:0] b_q[$];
  logic [16:0] b_exp;
  logic [16:0] b_hold_word;
  bit          b_hold;
  bit          b_exp_ready;
  bit          rw_done;
  int          accepted;
  int          b_written;
  int          b_popped;
  int          b_cyc;

  initial begin
    reset = 1'b1;
    {a_wr_valid, a_wr_last, a_rd_ready, a_rewind} = 4'b0000;
    {b_wr_valid, b_wr_last, b_rd_ready, b_rewind} = 4'b0000;
    {c_wr_valid, c_wr_last, c_rd_ready, c_rewind} = 4'b0000;
    a_wr_data = 8'h00; b_wr_data = 16'h0000; c_wr_data = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    check("a_reset_rd_valid", a_rd_valid, 1'b0);
    check("a_reset_count", a_count, 3'd0);
    check("a_reset_overflow", a_overflow, 1'b0);
    tick();
    check("a_wr_ready_after_reset", a_wr_ready, 1'b1);
    check("c_wr_ready_after_reset", c_wr_ready, 1'b1);

    // Back-to-back writes with the reader always ready.
    a_rd_ready = 1'b1;
    a_wr_valid = 1'b1; a_wr_data = 8'h11; tick();
    a_wr_data = 8'h22; tick();
    check("a_rd_valid_1_after", a_rd_valid, 1'b0);
    a_wr_data = 8'h33; tick();
    check("a_rd_valid_2_after", a_rd_valid, 1'b1);
    a_wr_valid = 1'b0;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (a_rd_valid && a_rd_ready) got.push_back(a_rd_data);
      tick();
    end
    check("a_seq_len", got.size(), 3);
    if (got.size() == 3) begin
      check("a_seq0", got[0], 8'h11);
      check("a_seq1", got[1], 8'h22);
      check("a_seq2", got[2], 8'h33);
    end
    check("a_count_drained", a_count, 3'd0);

    // Fill past capacity with the reader stalled.
    a_rd_ready = 1'b0;
    accepted   = 0;
    for (int i = 0; i < 5; i++) begin
      a_wr_valid = 1'b1;
      a_wr_data  = 8'(i + 1);
      if (a_wr_ready) accepted++;
      tick();
    end
    a_wr_valid = 1'b0;
    check("a_full_accepted", accepted, 4);
    check("a_full_count", a_count, 3'd4);
    check("a_full_wr_ready", a_wr_ready, 1'b0);
    check("a_full_overflow", a_overflow, 1'b1);
    check("a_full_head", {a_rd_valid, a_rd_data}, {1'b1, 8'h01});
    // Read from full while also offering a write: the write is still refused.
    a_rd_ready = 1'b1;
    a_wr_valid = 1'b1; a_wr_data = 8'h99;
    check("a_full_rd_wr_ready", a_wr_ready, 1'b0);
    tick();
    a_wr_valid = 1'b0;
    a_rd_ready = 1'b0;
    check("a_after_read_count", a_count, 3'd3);
    check("a_after_read_wr_ready", a_wr_ready, 1'b1);
    a_rd_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (a_rd_valid && a_rd_ready) got.push_back(a_rd_data);
      tick();
    end
    check("a_drain_len", got.size(), 3);
    if (got.size() == 3) begin
      check("a_drain0", got[0], 8'h02);
      check("a_drain1", got[1], 8'h03);
      check("a_drain2", got[2], 8'h04);
    end

    // Reset in the middle of a readout.
    a_rd_ready = 1'b0;
    a_wr_valid = 1'b1; a_wr_data = 8'h01; tick();
    a_wr_data = 8'h02; tick();
    a_wr_valid = 1'b0;
    tick();
    check("a_pre_reset_rd_valid", a_rd_valid, 1'b1);
    check("a_pre_reset_overflow", a_overflow, 1'b1);
    reset = 1'b1;
    #1;
    check("a_reset_now_rd_valid", a_rd_valid, 1'b0);
    check("a_reset_now_count", a_count, 3'd0);
    check("a_reset_now_overflow", a_overflow, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check("a_post_reset_wr_ready", a_wr_ready, 1'b1);
    a_rd_ready = 1'b1;
    a_wr_valid = 1'b1; a_wr_data = 8'h5A; tick();
    a_wr_data = 8'hA5; tick();
    a_wr_valid = 1'b0;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (a_rd_valid && a_rd_ready) got.push_back(a_rd_data);
      tick();
    end
    check("a_fresh_len", got.size(), 2);
    if (got.size() == 2) begin
      check("a_fresh0", got[0], 8'h5A);
      check("a_fresh1", got[1], 8'hA5);
    end

    // Replay: write a sealed three-entry program.
    c_write(8'h0A, 1'b0);
    c_write(8'h0B, 1'b0);
    c_write(8'h0C, 1'b1);
    check("c_count_sealed", c_count, 4'd3);
    c_write(8'h0D, 1'b0);
    check("c_count_refused", c_count, 4'd3);
    check("c_overflow", c_overflow, 1'b1);
    c_xfers = 0;
    repeat (10) c_cycle(1'b1, 1'b0);
    check("c_pass1_xfers", c_xfers, 3);
    check("c_end_rd_valid", c_rd_valid, 1'b0);
    check("c_count_after_read", c_count, 4'd3);
    // Rewind latency: entry 0 reappears two cycles after the request.
    c_cycle(1'b0, 1'b1);
    check("c_rw_cycle0", c_rd_valid, 1'b0);
    c_cycle(1'b0, 1'b0);
    check("c_rw_cycle1", c_rd_valid, 1'b0);
    c_cycle(1'b0, 1'b0);
    check("c_rw_cycle2", {c_rd_valid, c_rd_data}, {1'b1, 8'h0A});
    c_xfers = 0;
    repeat (10) c_cycle(1'b1, 1'b0);
    check("c_pass2_xfers", c_xfers, 3);
    c_cycle(1'b1, 1'b1);
    c_xfers = 0;
    repeat (10) c_cycle(1'b1, 1'b0);
    check("c_pass3_xfers", c_xfers, 3);
    // Rewind coincident with the transfer of B.
    c_cycle(1'b0, 1'b1);
    repeat (2) c_cycle(1'b0, 1'b0);
    c_cycle(1'b1, 1'b0);
    check("c_b_present", {c_rd_valid, c_rd_data}, {1'b1, 8'h0B});
    rw_done = 1'b0;
    for (int i = 0; i < 5 && !rw_done; i++) begin
      if (c_rd_valid) begin
        c_cycle(1'b1, 1'b1);
        rw_done = 1'b1;
        check("c_rw_drop", c_rd_valid, 1'b0);
      end else begin
        c_cycle(1'b0, 1'b0);
      end
    end
    check("c_rw_on_b_done", rw_done, 1'b1);
    c_xfers = 0;
    repeat (10) c_cycle(1'b1, 1'b0);
    check("c_pass4_xfers", c_xfers, 3);

    // Randomized FIFO traffic against a queue model; rewind must be ignored.
    b_written = 0; b_popped = 0; b_cyc = 0; b_hold = 1'b0;
    while (b_popped < 1000 && b_cyc < 20000) begin
      b_wr_valid = (b_written < 1000) && ($urandom_range(0, 3) != 0);
      b_wr_data  = 16'($urandom);
      b_wr_last  = 1'($urandom);
      b_rd_ready = ($urandom_range(0, 2) != 0);
      b_rewind   = ($urandom_range(0, 7) == 0);
      b_exp_ready = (b_q.size() < 8);
      check("b_wr_ready", b_wr_ready, b_exp_ready);
      check("b_count", b_count, b_q.size());
      if (b_hold) check("b_stall_hold", {b_rd_valid, b_rd_last, b_rd_data}, {1'b1, b_hold_word});
      if (b_rd_valid && b_rd_ready) begin
        if (b_q.size() == 0) begin
          check("b_rd_valid_empty", b_rd_valid, 1'b0);
        end else begin
          b_exp = b_q.pop_front();
          check("b_rd_data", {b_rd_last, b_rd_data}, b_exp);
          b_popped++;
        end
      end
      b_hold      = b_rd_valid && !b_rd_ready;
      b_hold_word = {b_rd_last, b_rd_data};
      if (b_wr_valid && b_exp_ready) begin
        b_q.push_back({b_wr_last, b_wr_data});
        b_written++;
      end
      tick();
      b_cyc++;
    end
    b_wr_valid = 1'b0;
    b_rd_ready = 1'b0;
    b_rewind   = 1'b0;
    check("b_popped_total", b_popped, 1000);
    check("b_final_count", b_count, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
